// File: rtl/parity_tx_pkg.sv
// Shared widths and state encoding for the parity-word serializer.
package parity_tx_pkg;

  localparam int WORD_W = 9;
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick_counter.sv
// Bit-period timer: Tick is high in the last clock of every bit period.
module baud_tick_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clear,
  output logic Tick
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign Tick = (cnt == CNT_LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (Clear || Tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_serial_tx.sv
// Serializes a pre-computed {parity, data} word as start, 8 data bits LSB first,
// the supplied parity bit and STOP_BITS stop bits, with a ready/valid input.
//
// state  | meaning
// IDLE   | line high, InReady=1, waiting for a word
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first
// PARITY | latched bit 8 for one bit period
// STOP   | line high for STOP_BITS bit periods; Done in last cycle
module parity_serial_tx
  import parity_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [WORD_W-1:0] InParity,
  input  logic              InValid,
  output logic              InReady,
  output logic              TxOut,
  output logic              Busy,
  output logic              Done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  tx_state_t         state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [1:0]        stop_cnt;
  logic              tick;
  logic              tx_nxt;
  logic              accept;

  baud_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clear (state == ST_IDLE),
    .Tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    accept    = 1'b0;
    shreg_nxt = shreg;
    tx_nxt    = 1'b1;

    case (state)
      ST_IDLE: begin
        InReady = 1'b1;
        Busy    = 1'b0;
        if (InValid) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:  if (tick) state_nxt = ST_DATA;
      ST_DATA:   if (tick && bit_idx == LAST_IDX) state_nxt = ST_PARITY;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP: begin
        if (tick && stop_cnt == LAST_STOP) begin
          Done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (accept) begin
      shreg_nxt = InParity;
    end else if (tick && state == ST_DATA) begin
      shreg_nxt = shreg >> 1;
    end

    // Line register follows the next state so it lines up with the FSM.
    case (state_nxt)
      ST_START:          tx_nxt = 1'b0;
      ST_DATA, ST_PARITY: tx_nxt = shreg_nxt[0];
      default:           tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      TxOut    <= 1'b1;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      TxOut <= tx_nxt;
      if (accept) begin
        bit_idx  <= '0;
        stop_cnt <= '0;
      end else if (tick) begin
        if (state == ST_DATA) bit_idx  <= bit_idx + 1'b1;
        if (state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/parity_serial_tx.md
# parity_serial_tx

Serializer that sits directly downstream of the 8-bit even-parity generator. It accepts one 9-bit word per transaction (bit 8 = parity, bits 7:0 = data) and shifts it onto a single UART-style line: start bit, data LSB-first, the supplied parity bit, then stop bit(s). The block forwards the parity bit unchanged and never recomputes it. A ready/valid handshake on the input and a one-cycle `Done` pulse let an upstream FIFO or controller stream words back to back.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range ≥ 2.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.
- `Clk` input 1: single clock; all state changes on its rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `InParity` input 9: {parity, data[7:0]} word from the parity generator.
- `InValid` input 1: `InParity` holds a word to send.
- `InReady` output 1: block can accept a word this cycle.
- `TxOut` output 1: serial line; idles high.
- `Busy` output 1: a frame is in progress.
- `Done` output 1: one-cycle pulse when a frame completes.

## Operation
- Reset values: `TxOut`=1, `InReady`=1, `Busy`=0, `Done`=0, state IDLE, counters 0.
- A word is accepted on a rising edge where `InValid && InReady`. `InParity` is latched into an internal 9-bit shift register on that edge. After acceptance, the input is don't-care.
- State machine:
  - IDLE: `InReady`=1, `TxOut`=1. On accept, go to START.
  - START: `TxOut`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, bit 0 first, each for `CLKS_PER_BIT` cycles. A 3-bit index counts them; after index 7, go to PARITY.
  - PARITY: `TxOut`=latched bit 8, then go to STOP.
  - STOP: `TxOut`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE.
- `Busy`=1 in every state except IDLE. `InReady`=1 only in IDLE.
- `Done` is asserted in the last cycle of STOP.
- The bit-period counter counts 0…`CLKS_PER_BIT`−1 and wraps to 0 on each bit boundary. It is reset to 0 on accept.
- `TxOut` is driven from a register, so it never glitches.
- Reset asserted mid-frame aborts the frame:
  - `TxOut` returns to 1 asynchronously.
  - No `Done` is produced.
  - The partially sent word is discarded.
- `InValid` asserted while `Busy` is ignored. The word is not latched and is not lost as long as upstream holds it; it is taken in the first IDLE cycle.

## Timing
- Accept edge at cycle T. `TxOut` falls at T+1 (start bit begins).
- Data bit k starts at T+1+(1+k)×`CLKS_PER_BIT`.
- The parity bit starts at T+1+9×`CLKS_PER_BIT`.
- Frame length is F=(10+`STOP_BITS`)×`CLKS_PER_BIT` cycles.
- `Done` is high during cycle T+F. IDLE is re-entered at T+F+1, where `InReady`=1.
- Back to back: with `InValid` held high, the next accept occurs at T+F+1. Line throughput is 1 word per F+1 cycles; the single extra cycle is an idle-high gap.
- `Rst` deassertion is synchronised by the integrator. The block may accept a word on the first edge after deassertion.

## Structure
- Shared package `parity_tx_pkg`:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - `WORD_W`=9 and `DATA_W`=8;
  - the bit-index width.
- Sub-module `baud_tick_counter` (parameter `CLKS_PER_BIT`; inputs `Clk`, `Rst`, `Clear`; output `Tick`, high in the last cycle of each bit period). The FSM advances only on `Tick`.
- The parent holds the FSM, the 9-bit shift register, the bit index, the stop-bit counter and the output registers.

## Test plan
- Reset, no stimulus: `TxOut`=1, `InReady`=1, `Busy`=0, `Done`=0 for 100 cycles.
- Send `InParity`=9'h0AA (data 10101010, parity 0), `CLKS_PER_BIT`=4:
  - line sequence sampled mid-bit is 0,0,1,0,1,0,1,0,1,0,1;
  - `Done` occurs exactly 44 cycles after accept.
- Back-to-back 9'h1AB then 9'h18C with `InValid` held high:
  - second accept occurs at first accept + 45;
  - parity bits on the line are 1 and 1;
  - `InReady` is low throughout each frame.
- `STOP_BITS`=2, send 9'h0FF: stop level lasts 8 cycles (at `CLKS_PER_BIT`=4) and `Done` occurs at accept + 48.
- Assert `Rst` during data bit 3 of 9'h0AA:
  - `TxOut`=1 immediately (before the next edge);
  - no `Done` pulse;
  - after release, sending 9'h000 produces a clean frame.
- Toggle `InValid` while `Busy` with differing `InParity` values: only the word present at the IDLE accept edge appears on the line.
